// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 encodings, FSM state codes and lane helpers for the data-memory responder
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3)
      F3_SB:   be = 4'b0001 << addr_lo;
      F3_SH:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (funct3)
      F3_SB:   lanes = {4{wdata[7:0]}};
      F3_SH:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic access_legal(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~addr_lo[0];
        F3_SW:   ok = (addr_lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~addr_lo[0];
        F3_LW:         ok = (addr_lo == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   res = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   res = {{16{sh[15]}}, sh[15:0]};
      F3_LW:   res = sh;
      F3_LBU:  res = {24'h0, sh[7:0]};
      F3_LHU:  res = {16'h0, sh[15:0]};
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// rtl/dmem_sram_bank.sv - single-port 4-lane byte-enable memory bank with registered read data
module dmem_sram_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // No reset: contents must survive a responder reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage load/store responder: lane rules, alignment checks, load formatting
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy_o
);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W+1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_legal;
  logic              w_bank_en;
  logic [31:0]       w_bank_rdata;
  logic              w_unused_addr;

  // Bits above the word index are dropped, so the array wraps.
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  assign w_accept = req_valid & r_ready;
  assign w_legal  = access_legal(r_we, r_funct3, r_addr[1:0]);
  assign w_bank_en = (r_state == ST_ACCESS) & w_legal;

  dmem_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .i_en    (w_bank_en),
    .i_we    (r_we),
    .i_be    (be_gen(r_funct3, r_addr[1:0])),
    .i_addr  (r_addr[ADDR_W+1:2]),
    .i_wdata (store_lanes(r_funct3, r_wdata)),
    .o_rdata (w_bank_rdata)
  );

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_next = w_accept ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_funct3    <= 3'b000;
      r_wdata     <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr[ADDR_W+1:0];
        r_funct3 <= req_funct3;
        r_wdata  <= req_wdata;
      end
      // Bank read data is valid in RESP; the response is registered on the way out.
      r_rsp_valid <= (r_state == ST_RESP);
      if (r_state == ST_RESP) begin
        r_rsp_err   <= ~w_legal;
        r_rsp_rdata <= (w_legal & ~r_we) ? load_fmt(r_funct3, r_addr[1:0], w_bank_rdata) : 32'h0;
      end else begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= 32'h0;
      end
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed bench for dmem_responder against a byte-array model
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int MEMB  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy_o;

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endtask

  // Behavioural model: byte-addressed memory and a "cycles since accept" counter.
  logic [7:0]  m_mem [MEMB];
  int          since = -1;
  logic        exp_ready = 1'b0;
  logic        exp_rsp_valid = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0;
  logic        pend_we = 1'b0;
  int unsigned pend_a, pend_sz;
  logic [31:0] pend_data;
  logic [31:0] res_data;
  logic        res_err;

  task automatic model_accept();
    int unsigned a, sz;
    logic known;
    logic [31:0] v;
    a = req_addr % MEMB;
    known = 1'b1;
    sz = 1;
    case (req_funct3[1:0])
      2'd0: sz = 1;
      2'd1: sz = 2;
      2'd2: sz = 4;
      default: known = 1'b0;
    endcase
    if (req_funct3[2] && (req_we || req_funct3[1])) known = 1'b0;
    res_data = 32'h0;
    res_err  = 1'b0;
    if (!known || (a % sz) != 0) begin
      res_err = 1'b1;
    end else if (req_we) begin
      pend_we = 1'b1; pend_a = a; pend_sz = sz; pend_data = req_wdata;
    end else begin
      v = 32'h0;
      for (int i = 0; i < 4; i++) if (i < sz) v = v | (32'(m_mem[a+i]) << (8*i));
      if (!req_funct3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 1);
      res_data = v;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since = -1; exp_ready = 1'b0; exp_rsp_valid = 1'b0;
      exp_rdata = 32'h0; exp_err = 1'b0; pend_we = 1'b0;
    end else begin
      exp_rsp_valid = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
      if (since == 0) begin
        if (pend_we)
          for (int i = 0; i < 4; i++) if (i < pend_sz) m_mem[pend_a+i] = pend_data[8*i +: 8];
        pend_we = 1'b0;
        since = 1;
      end else if (since == 1) begin
        exp_rsp_valid = 1'b1; exp_rdata = res_data; exp_err = res_err;
        since = -1; exp_ready = 1'b1;
      end else if (exp_ready && req_valid) begin
        model_accept();
        since = 0; exp_ready = 1'b0;
      end else begin
        exp_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
    chk("busy_o", {31'h0, busy_o}, {31'h0, since != -1});
    chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rsp_valid});
    if (exp_rsp_valid) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: got no ready expected ready within 20 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    rd = 32'h0; er = 1'b0; t = 0;
    while (t < 8) begin
      @(negedge clk);
      if (rsp_valid) begin rd = rsp_rdata; er = rsp_err; break; end
      t++;
    end
    if (t == 8) begin
      n_checks++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 8 cycles");
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          acc, last, nrsp, cyc, seen;
  logic        took;

  task automatic lit(input string name, input logic w, input logic [31:0] a, input logic [2:0] f,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic e;
    do_req(w, a, f, wd, d, e);
    chk({name, "_data"}, d, exp_d);
    chk({name, "_err"}, {31'h0, e}, {31'h0, exp_e});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'h0, req_ready}, 32'h0);
    chk("reset_rsp", {rsp_rdata[30:0], rsp_valid | rsp_err | busy_o | rsp_rdata[31]}, 32'h0);
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++) do_req(1'b1, 32'(w*4), 3'b010, (32'(w) * 32'h01010101) ^ 32'h5A5AA5A5, rd, er);

    lit("sw_10",  1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
    lit("lw_10",  1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
    lit("lb_13",  1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
    lit("lbu_13", 1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0);
    lit("lh_12",  1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0);
    lit("lhu_10", 1'b0, 32'h10, 3'b101, 32'h0, 32'h0000BEEF, 1'b0);
    lit("sb_11",  1'b1, 32'h11, 3'b000, 32'h12345655, 32'h0, 1'b0);
    lit("lw_sb",  1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0);
    lit("sh_12",  1'b1, 32'h12, 3'b001, 32'h0000A5A5, 32'h0, 1'b0);
    lit("lw_sh",  1'b0, 32'h10, 3'b010, 32'h0, 32'hA5A555EF, 1'b0);
    lit("lw_mis", 1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1);
    lit("sh_mis", 1'b1, 32'h13, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1);
    lit("f3_011", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
    lit("lw_keep", 1'b0, 32'h10, 3'b010, 32'h0, 32'hA5A555EF, 1'b0);
    lit("sw_wrap", 1'b1, 32'(DEPTH*4 + 32'h20), 3'b010, 32'h11111111, 32'h0, 1'b0);
    lit("lw_wrap", 1'b0, 32'h20, 3'b010, 32'h0, 32'h11111111, 1'b0);

    // Reset while a store sits in ACCESS: no response, no write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'hCAFEF00D;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("abort_no_rsp", 32'(seen), 32'h0);
    rst_n = 1'b1;
    #1 chk("ready_at_release", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    chk("ready_after_edge", {31'h0, req_ready}, 32'h1);
    lit("lw_abort", 1'b0, 32'h10, 3'b010, 32'h0, 32'hA5A555EF, 1'b0);

    // Held req_valid with four queued stores.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h44440000;
    acc = 0; last = 0; nrsp = 0; cyc = 0;
    while (acc < 4 && cyc < 60) begin
      if (rsp_valid) nrsp++;
      took = req_ready;
      if (took) begin
        if (acc > 0) chk("accept_gap", 32'(cyc - last), 32'd3);
        last = cyc; acc++;
      end
      @(posedge clk); #1;
      if (took) begin
        req_addr = req_addr + 32'h4; req_wdata = req_wdata + 32'h1;
        if (acc == 4) req_valid = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    chk("accepts", 32'(acc), 32'd4);
    repeat (6) begin if (rsp_valid) nrsp++; @(negedge clk); end
    chk("rsp_count", 32'(nrsp), 32'd4);

    // Random traffic confined to the initialised words, with random upper address bits.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 2) != 0);
      req_we = 1'($urandom);
      if ($urandom_range(0, 7) == 0) req_funct3 = 3'($urandom);
      else req_funct3 = req_we ? 3'($urandom_range(0, 2)) : ((3'($urandom_range(0, 4)) == 3'd3) ? 3'b100 : 3'($urandom_range(0, 2)));
      if (!req_we && $urandom_range(0, 3) == 0) req_funct3 = 3'b101;
      req_addr = ($urandom << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      req_wdata = $urandom;
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
